// File: rtl/mem_bus_tracer.sv
// Passive memory-bus tracer: captures read/write transactions into a FIFO
// with per-type transaction counters and sticky overflow/illegal-strobe flags.
module mem_bus_tracer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   ADDR,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [DATA_WIDTH-1:0]   MEM_DATA_IN,
  input  logic [DATA_WIDTH-1:0]   MEM_DATA_OUT,
  input  logic                    EN,
  input  logic                    POP,
  input  logic                    CLR_FLAGS,
  output logic                    TRACE_VALID,
  output logic                    TRACE_WR,
  output logic [ADDR_WIDTH-1:0]   TRACE_ADDR,
  output logic [DATA_WIDTH-1:0]   TRACE_DATA,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic [15:0]             RD_CNT,
  output logic [15:0]             WR_CNT,
  output logic                    OVERFLOW,
  output logic                    ILLEGAL
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_next;
  logic                    pend_wr;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic [ENT_W-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        level_next;

  logic rd_s, wr_s, bus_valid, bus_illegal, same_txn;
  logic latch, commit;
  logic full, empty, do_pop, do_push, ovf_set;

  assign rd_s        = READ & ~WRITE;
  assign wr_s        = WRITE & ~READ;
  assign bus_valid   = rd_s | wr_s;
  assign bus_illegal = READ & WRITE;
  assign same_txn    = bus_valid && (wr_s == pend_wr) && (ADDR == pend_addr);

  assign full       = (LEVEL == LVL_W'(DEPTH));
  assign empty      = (LEVEL == '0);
  assign do_pop     = POP && !empty;
  assign do_push    = commit && (!full || do_pop);
  assign ovf_set    = commit && full && !do_pop;
  assign level_next = LEVEL + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // A transaction ends on any change of strobe/address; a new valid strobe
  // is captured in that same cycle so back-to-back accesses leave no gap.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (EN && bus_valid) begin
          latch      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (same_txn) begin
          latch = 1'b1;
        end else begin
          commit = 1'b1;
          if (EN && bus_valid) latch = 1'b1;
          else                 state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Trace storage has no reset; validity is tracked by LEVEL.
  always_ff @(posedge CLK) begin
    if (!RST && do_push) mem[wr_ptr] <= {pend_wr, pend_addr, pend_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_wr     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      LEVEL       <= '0;
      TRACE_VALID <= 1'b0;
      TRACE_WR    <= 1'b0;
      TRACE_ADDR  <= '0;
      TRACE_DATA  <= '0;
      RD_CNT      <= '0;
      WR_CNT      <= '0;
      OVERFLOW    <= 1'b0;
      ILLEGAL     <= 1'b0;
    end else begin
      if (latch) begin
        pend_wr   <= wr_s;
        pend_addr <= ADDR;
        pend_data <= wr_s ? MEM_DATA_IN : MEM_DATA_OUT;
      end
      if (commit) begin
        if (pend_wr) WR_CNT <= WR_CNT + 16'd1;
        else         RD_CNT <= RD_CNT + 16'd1;
      end
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      LEVEL       <= level_next;
      TRACE_VALID <= (level_next != '0);
      // Head register follows the entry that will sit at rd_ptr after this edge.
      if (do_push && (empty || (do_pop && LEVEL == LVL_W'(1))))
        {TRACE_WR, TRACE_ADDR, TRACE_DATA} <= {pend_wr, pend_addr, pend_data};
      else if (do_pop && LEVEL > LVL_W'(1))
        {TRACE_WR, TRACE_ADDR, TRACE_DATA} <= mem[rd_ptr + PTR_W'(1)];
      OVERFLOW <= ovf_set     | (OVERFLOW & ~CLR_FLAGS);
      ILLEGAL  <= bus_illegal | (ILLEGAL  & ~CLR_FLAGS);
    end
  end

endmodule

// File: tb/tb_mem_bus_tracer.sv
// Bench for mem_bus_tracer: directed scenarios plus randomized bus traffic,
// compared every cycle against a queue-based transaction model.
module tb_mem_bus_tracer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 26;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] ADDR = '0;
  logic          READ = 1'b0, WRITE = 1'b0;
  logic [DW-1:0] MEM_DATA_IN = '0, MEM_DATA_OUT = '0;
  logic          EN = 1'b0, POP = 1'b0, CLR_FLAGS = 1'b0;
  logic          TRACE_VALID, TRACE_WR;
  logic [AW-1:0] TRACE_ADDR;
  logic [DW-1:0] TRACE_DATA;
  logic [LW-1:0] LEVEL;
  logic [15:0]   RD_CNT, WR_CNT;
  logic          OVERFLOW, ILLEGAL;

  mem_bus_tracer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .READ(READ), .WRITE(WRITE),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(MEM_DATA_OUT), .EN(EN),
    .POP(POP), .CLR_FLAGS(CLR_FLAGS), .TRACE_VALID(TRACE_VALID),
    .TRACE_WR(TRACE_WR), .TRACE_ADDR(TRACE_ADDR), .TRACE_DATA(TRACE_DATA),
    .LEVEL(LEVEL), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT),
    .OVERFLOW(OVERFLOW), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: open transaction plus a queue of committed entries.
  ent_t        m_q[$];
  bit          m_open;
  ent_t        m_pend;
  logic [15:0] m_rd, m_wr;
  bit          m_ovf, m_ill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit   is_rd, is_wr, pop_ok, do_commit;
    ent_t done, fresh;
    if (RST) begin
      m_q.delete(); m_open = 0; m_rd = 0; m_wr = 0; m_ovf = 0; m_ill = 0;
      return;
    end
    is_rd = READ && !WRITE;
    is_wr = WRITE && !READ;
    fresh = '{wr: is_wr, addr: ADDR, data: is_wr ? MEM_DATA_IN : MEM_DATA_OUT};
    do_commit = 0;
    if (m_open) begin
      if ((is_rd || is_wr) && is_wr == m_pend.wr && ADDR == m_pend.addr) begin
        m_pend.data = fresh.data;
      end else begin
        do_commit = 1;
        done = m_pend;
        m_open = (is_rd || is_wr) && EN;
        if (m_open) m_pend = fresh;
      end
    end else if ((is_rd || is_wr) && EN) begin
      m_open = 1;
      m_pend = fresh;
    end
    pop_ok = POP && m_q.size() > 0;
    m_ovf  = (m_ovf && !CLR_FLAGS);
    m_ill  = (READ && WRITE) || (m_ill && !CLR_FLAGS);
    if (do_commit) begin
      if (done.wr) m_wr = m_wr + 16'd1;
      else         m_rd = m_rd + 16'd1;
      if (m_q.size() == DEPTH && !pop_ok) m_ovf = 1;
    end
    if (pop_ok) void'(m_q.pop_front());
    if (do_commit && m_q.size() < DEPTH) m_q.push_back(done);
  endtask

  task automatic compare_all();
    check("level",    64'(LEVEL),       64'(m_q.size()));
    check("valid",    64'(TRACE_VALID), 64'(m_q.size() != 0));
    check("rd_cnt",   64'(RD_CNT),      64'(m_rd));
    check("wr_cnt",   64'(WR_CNT),      64'(m_wr));
    check("overflow", 64'(OVERFLOW),    64'(m_ovf));
    check("illegal",  64'(ILLEGAL),     64'(m_ill));
    if (m_q.size() != 0) begin
      check("head_wr",   64'(TRACE_WR),   64'(m_q[0].wr));
      check("head_addr", 64'(TRACE_ADDR), 64'(m_q[0].addr));
      check("head_data", 64'(TRACE_DATA), 64'(m_q[0].data));
    end
  endtask

  task automatic cycle(input bit rst, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] din, input logic [DW-1:0] dout,
                       input bit en, input bit pop, input bit clr);
    RST = rst; READ = rd; WRITE = wr; ADDR = a; MEM_DATA_IN = din;
    MEM_DATA_OUT = dout; EN = en; POP = pop; CLR_FLAGS = clr;
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit pop);
    cycle(0, 0, 0, '0, '0, '0, 1, pop, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0, '0, '0, 1, 1, 1);
    check("rst_wr",   64'(TRACE_WR),   64'(0));
    check("rst_addr", 64'(TRACE_ADDR), 64'(0));
    check("rst_data", 64'(TRACE_DATA), 64'(0));
  endtask

  initial begin
    bit            rd, wr, both, keep;
    logic [AW-1:0] a;

    #1;
    do_reset();

    // Two-cycle write becomes a single entry.
    cycle(0, 0, 1, 26'h0040000, 32'h5, 32'h0, 1, 0, 0);
    cycle(0, 0, 1, 26'h0040000, 32'h5, 32'h0, 1, 0, 0);
    idle(0);
    check("w36_level", 64'(LEVEL), 64'(1));
    check("w36_wrcnt", 64'(WR_CNT), 64'(1));
    check("w36_data",  64'(TRACE_DATA), 64'(32'h5));

    // Read with latency: last cycle's data is captured.
    do_reset();
    cycle(0, 1, 0, 26'h3FFFFFF, 32'h0, 32'h0, 1, 0, 0);
    cycle(0, 1, 0, 26'h3FFFFFF, 32'h0, 32'h0, 1, 0, 0);
    cycle(0, 1, 0, 26'h3FFFFFF, 32'h0, 32'hDEADBEEF, 1, 0, 0);
    idle(0);
    check("r37_data",  64'(TRACE_DATA), 64'(32'hDEADBEEF));
    check("r37_rdcnt", 64'(RD_CNT), 64'(1));

    // Back-to-back reads, then drain in order.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, AW'(16 + i), 32'h0, DW'(100 + i), 1, 0, 0);
    idle(0);
    check("b38_level", 64'(LEVEL), 64'(3));
    check("b38_rdcnt", 64'(RD_CNT), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check("b38_order", 64'(TRACE_ADDR), 64'(16 + i));
      idle(1);
    end
    idle(1);
    check("b38_empty", 64'(LEVEL), 64'(0));

    // Overflow, then commit+pop while full.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, AW'(i), DW'(i * 7), 32'h0, 1, 0, 0);
    idle(0);
    check("o39_level", 64'(LEVEL), 64'(16));
    check("o39_ovf",   64'(OVERFLOW), 64'(1));
    check("o39_wrcnt", 64'(WR_CNT), 64'(17));
    check("o39_head",  64'(TRACE_ADDR), 64'(0));
    cycle(0, 0, 1, 26'h100, 32'h55, 32'h0, 1, 0, 0);
    idle(1);
    check("o39_full_pop", 64'(LEVEL), 64'(16));
    check("o39_head2",    64'(TRACE_ADDR), 64'(1));

    // Illegal strobe from idle, then clear.
    do_reset();
    cycle(0, 1, 1, 26'h20, 32'h1, 32'h2, 1, 0, 0);
    idle(0);
    check("i40_level", 64'(LEVEL), 64'(0));
    check("i40_ill",   64'(ILLEGAL), 64'(1));
    cycle(0, 0, 0, '0, '0, '0, 1, 0, 1);
    check("i40_clr",   64'(ILLEGAL), 64'(0));

    // Reset mid-read discards the open transaction.
    do_reset();
    cycle(0, 1, 0, 26'h30, 32'h0, 32'h77, 1, 0, 0);
    cycle(1, 1, 0, 26'h30, 32'h0, 32'h77, 1, 0, 0);
    check("x41_level", 64'(LEVEL), 64'(0));
    check("x41_rdcnt", 64'(RD_CNT), 64'(0));
    idle(0);
    check("x41_after", 64'(RD_CNT), 64'(0));

    // Randomized traffic with held strobes to exercise data re-latching.
    do_reset();
    rd = 0; wr = 0; a = '0;
    for (int i = 0; i < 4000; i++) begin
      keep = ($urandom_range(0, 2) != 0);
      if (!keep) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin rd = 1; wr = 0; end
          4, 5, 6, 7: begin rd = 0; wr = 1; end
          8:          begin rd = 0; wr = 0; end
          default: begin
            both = ($urandom_range(0, 3) == 0);
            rd = both; wr = both;
          end
        endcase
        a = AW'($urandom_range(0, 3));
      end
      cycle(($urandom_range(0, 299) == 0), rd, wr, a, DW'($urandom), DW'($urandom),
            ($urandom_range(0, 7) != 0),
            (((i / 400) % 2) == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_tracer.md
MEM_BUS_TRACER -- requirements
Module: mem_bus_tracer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory data bus width.
REQ-002 Parameter ADDR_WIDTH, default 26, memory address bus width.
REQ-003 Parameter DEPTH, default 16, trace FIFO entries (power of 2, >=2).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 ADDR  input  ADDR_WIDTH  processor memory address, sampled from the processor/memory bus.
REQ-007 READ, WRITE  input  1 each  processor memory strobes.
REQ-008 MEM_DATA_IN  input  DATA_WIDTH  write data from processor to memory.
REQ-009 MEM_DATA_OUT  input  DATA_WIDTH  read data from memory to processor.
REQ-010 EN  input  1  capture enable; 0 suppresses new transaction starts.
REQ-011 POP  input  1  consumer pops head entry when TRACE_VALID=1.
REQ-012 CLR_FLAGS  input  1  clears OVERFLOW and ILLEGAL.
REQ-013 TRACE_VALID  output  1  FIFO non-empty; TRACE_* show head entry.
REQ-014 TRACE_WR  output  1  head type: 1 write, 0 read.
REQ-015 TRACE_ADDR / TRACE_DATA  output  ADDR_WIDTH / DATA_WIDTH  head address/data.
REQ-016 LEVEL  output  log2(DEPTH)+1  FIFO occupancy.
REQ-017 RD_CNT, WR_CNT  output  16 each  completed read/write transactions (incl. dropped).
REQ-018 OVERFLOW, ILLEGAL  output  1 each  sticky error flags.

Function
REQ-019 Transaction strobe: READ=1,WRITE=0 (read) or READ=0,WRITE=1 (write); READ=WRITE=1 is illegal.
REQ-020 FSM states IDLE, ACTIVE; reset state IDLE.
REQ-021 IDLE->ACTIVE when EN=1 and valid strobe: latch type, ADDR, data (MEM_DATA_OUT for read, MEM_DATA_IN for write).
REQ-022 In ACTIVE, each cycle with same strobe type and same ADDR re-latches data (last-cycle data wins, covers read latency).
REQ-023 ACTIVE ends when strobe drops, type changes or ADDR changes: pending entry is committed that cycle (push next edge); if a new valid strobe is present and EN=1, FSM stays ACTIVE and latches the new transaction in the same cycle (back-to-back, no gap).
REQ-024 EN deassertion during ACTIVE does not abort the pending transaction.
REQ-025 Commit increments RD_CNT or WR_CNT by 1, wrapping 0xFFFF->0x0000.
REQ-026 Commit with FIFO full and no POP in the same cycle: entry dropped, OVERFLOW set; counters still increment.
REQ-027 Commit and POP in same cycle: both performed; LEVEL unchanged, even when full.
REQ-028 POP with TRACE_VALID=0 ignored; LEVEL never underflows.
REQ-029 FIFO is first-in first-out; pointers wrap modulo DEPTH; TRACE_* are registered head values, updated the cycle after push-to-empty or pop.
REQ-030 Illegal strobe: ILLEGAL set; in IDLE no transaction starts; in ACTIVE it ends the pending transaction (committed per REQ-023).
REQ-031 CLR_FLAGS clears flags next edge; a same-cycle set event wins over clear.
REQ-032 Monitor is passive: no outputs drive the memory bus.

Reset
REQ-033 RST=1 at an edge: FSM IDLE, FIFO empty, LEVEL=0, TRACE_VALID=0, TRACE_WR=0, TRACE_ADDR=0, TRACE_DATA=0, RD_CNT=WR_CNT=0, OVERFLOW=ILLEGAL=0.
REQ-034 RST during ACTIVE discards the pending transaction without commit or count.
REQ-035 RST overrides all inputs, including POP and CLR_FLAGS.

Verification
REQ-036 Write ADDR=0x0040000, MEM_DATA_IN=0x00000005, WRITE held 2 cycles -> one entry {WR=1, 0x0040000, 0x00000005}, WR_CNT=1, LEVEL=1.
REQ-037 Read ADDR=0x3FFFFFF held 3 cycles, MEM_DATA_OUT 0x0,0x0,0xDEADBEEF -> entry {WR=0, 0x3FFFFFF, 0xDEADBEEF}, RD_CNT=1.
REQ-038 Back-to-back reads at 0x10,0x11,0x12, one cycle each, no gap -> 3 entries in order, RD_CNT=3.
REQ-039 17 single-cycle writes, no POP -> LEVEL=16, OVERFLOW=1, WR_CNT=17, head = first write; then commit+POP same cycle at full -> LEVEL stays 16.
REQ-040 READ=WRITE=1 for 1 cycle from IDLE -> no entry, ILLEGAL=1; CLR_FLAGS pulse -> ILLEGAL=0.
REQ-041 RST=1 mid-read after 1 cycle -> LEVEL=0, RD_CNT=0, all outputs at reset values next cycle.
